// File: rtl/axi_rx_pkg.sv
// Shared types and default sizes for the RX storage path.
// The FSM state encoding is kept here so the debug port and benches agree on it.
package axi_rx_pkg;

    localparam int RX_WIDTH_DEF = 8;
    localparam int RX_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        CLR   = 2'd2,
        BLOCK = 2'd3
    } rx_store_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for the RX FIFO.
// Writes land on the rising edge; the read port is combinational for first-word-fall-through.
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; occupancy tracking makes stale data invisible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_store_fifo.sv
// Stores beats latched by RX_channel into a FWFT FIFO and paces RX_channel through rx_hold.
// A beat is taken from IDLE or BLOCK only; ACK then CLR follow every write.
module rx_store_fifo
    import axi_rx_pkg::*;
#(
    parameter int WIDTH = RX_WIDTH_DEF,
    parameter int DEPTH = RX_DEPTH_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_new_data,
    output logic             rx_hold,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      count,
    output logic             full,
    output logic [1:0]       dbg_state
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    rx_store_state_t state_q, state_d;
    logic            rx_hold_q, rx_hold_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full_w;
    logic            push;
    logic            pop;

    assign full_w = (count_q == FULL_CNT);

    always_comb begin
        state_d   = state_q;
        rx_hold_d = rx_hold_q;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_w) begin
                    state_d   = BLOCK;
                    rx_hold_d = 1'b1;
                end else if (rx_new_data) begin
                    push      = 1'b1;
                    state_d   = ACK;
                    rx_hold_d = 1'b1;
                end else begin
                    rx_hold_d = 1'b0;
                end
            end
            // Falling rx_hold after ACK is RX_channel's clear strobe.
            ACK: begin
                state_d   = CLR;
                rx_hold_d = 1'b0;
            end
            // rx_new_data may still show the beat just stored, so it is ignored here.
            CLR: begin
                state_d   = IDLE;
                rx_hold_d = 1'b0;
            end
            BLOCK: begin
                if (!full_w && rx_new_data) begin
                    push      = 1'b1;
                    state_d   = ACK;
                    rx_hold_d = 1'b1;
                end else if (!full_w) begin
                    state_d   = CLR;
                    rx_hold_d = 1'b0;
                end else begin
                    rx_hold_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                rx_hold_d = 1'b0;
            end
        endcase
    end

    // Pop handshake: the head is consumed on any edge where out_valid and out_ready
    // are both high; out_valid never depends on out_ready, and out_ready while empty is ignored.
    assign pop = (count_q != '0) && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            rx_hold_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rx_hold_q <= rx_hold_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (ACLK),
        .we   (push),
        .waddr(wr_ptr_q),
        .wdata(rx_data),
        .raddr(rd_ptr_q),
        .rdata(out_data)
    );

    assign rx_hold   = rx_hold_q;
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign full      = full_w;
    assign dbg_state = state_q;

endmodule
